// File: rtl/cplx_addsub_acc.sv
// Complex add/sub/accumulate with saturating or wrapping narrowing; S1 wide result -> S2 narrowed output.
// Latency 2 edges from accept (from the in_last beat for runs); valid/ready stalls hold S2 and fill S1, then in_ready drops.
module cplx_addsub_acc #(
   parameter int W        = 13,
   parameter int GUARD    = 4,
   parameter int SATURATE = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [1:0]   mode,
   input  logic         in_last,
   input  logic [W-1:0] a_real,
   input  logic [W-1:0] a_imag,
   input  logic [W-1:0] b_real,
   input  logic [W-1:0] b_imag,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_real,
   output logic [W-1:0] out_imag,
   output logic         out_ovf
);

   localparam int AW = W + GUARD;
   localparam logic [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

   function automatic logic [AW-1:0] sext(input logic [W-1:0] v);
      return {{GUARD{v[W-1]}}, v};
   endfunction

   // In range when every bit above the W-bit sign position matches it.
   function automatic logic fits(input logic [AW-1:0] v);
      return (&v[AW-1:W-1]) || !(|v[AW-1:W-1]);
   endfunction

   function automatic logic [W-1:0] narrow(input logic [AW-1:0] v);
      if (fits(v) || SATURATE == 0) return v[W-1:0];
      return v[AW-1] ? MINV : MAXV;
   endfunction

   logic          s1_vld_q, s1_vld_d;
   logic [AW-1:0] s1_re_q, s1_re_d, s1_im_q, s1_im_d;
   logic [AW-1:0] acc_re_q, acc_re_d, acc_im_q, acc_im_d;
   logic          first_q, first_d;
   logic          out_vld_q, out_vld_d;
   logic [W-1:0]  out_re_q, out_re_d, out_im_q, out_im_d;
   logic          ovf_q, ovf_d;

   logic          en, fire, is_acc, is_sub;
   logic [AW-1:0] a_re_x, a_im_x, b_re_x, b_im_x;
   logic [AW-1:0] sum_re, sum_im, acc_nx_re, acc_nx_im;

   always_comb begin
      en        = !out_vld_q || out_ready;
      in_ready  = !s1_vld_q || en;
      fire      = in_valid && in_ready;
      is_acc    = (mode == 2'b10);
      is_sub    = (mode == 2'b01);
      a_re_x    = sext(a_real);
      a_im_x    = sext(a_imag);
      b_re_x    = sext(b_real);
      b_im_x    = sext(b_imag);
      sum_re    = is_sub ? a_re_x - b_re_x : a_re_x + b_re_x;
      sum_im    = is_sub ? a_im_x - b_im_x : a_im_x + b_im_x;
      acc_nx_re = (first_q ? '0 : acc_re_q) + a_re_x;
      acc_nx_im = (first_q ? '0 : acc_im_q) + a_im_x;

      s1_vld_d  = s1_vld_q;
      s1_re_d   = s1_re_q;
      s1_im_d   = s1_im_q;
      acc_re_d  = acc_re_q;
      acc_im_d  = acc_im_q;
      first_d   = first_q;
      out_vld_d = out_vld_q;
      out_re_d  = out_re_q;
      out_im_d  = out_im_q;
      ovf_d     = ovf_q;

      if (en) begin
         out_vld_d = s1_vld_q;
         if (s1_vld_q) begin
            out_re_d = narrow(s1_re_q);
            out_im_d = narrow(s1_im_q);
            ovf_d    = !fits(s1_re_q) || !fits(s1_im_q);
         end
         s1_vld_d = 1'b0;
      end

      // Drain above, reload below: both may happen in one cycle.
      if (fire) begin
         if (!is_acc) begin
            s1_vld_d = 1'b1;
            s1_re_d  = sum_re;
            s1_im_d  = sum_im;
         end else if (in_last) begin
            s1_vld_d = 1'b1;
            s1_re_d  = acc_nx_re;
            s1_im_d  = acc_nx_im;
            first_d  = 1'b1;
         end else begin
            acc_re_d = acc_nx_re;
            acc_im_d = acc_nx_im;
            first_d  = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld_q  <= 1'b0;
         s1_re_q   <= '0;
         s1_im_q   <= '0;
         acc_re_q  <= '0;
         acc_im_q  <= '0;
         first_q   <= 1'b1;
         out_vld_q <= 1'b0;
         out_re_q  <= '0;
         out_im_q  <= '0;
         ovf_q     <= 1'b0;
      end else begin
         s1_vld_q  <= s1_vld_d;
         s1_re_q   <= s1_re_d;
         s1_im_q   <= s1_im_d;
         acc_re_q  <= acc_re_d;
         acc_im_q  <= acc_im_d;
         first_q   <= first_d;
         out_vld_q <= out_vld_d;
         out_re_q  <= out_re_d;
         out_im_q  <= out_im_d;
         ovf_q     <= ovf_d;
      end
   end

   assign out_valid = out_vld_q;
   assign out_real  = out_re_q;
   assign out_imag  = out_im_q;
   assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_cplx_addsub_acc.sv
// Bench for cplx_addsub_acc: saturating and wrapping instances share stimulus; vector table plus randomized scoreboard.
module tb_cplx_addsub_acc;

   localparam int W  = 13;
   localparam int AW = 17;

   logic         clk, rst_n, in_valid, out_ready, in_last;
   logic [1:0]   mode;
   logic [W-1:0] a_real, a_imag, b_real, b_imag;
   logic         s_in_ready, s_out_valid, s_out_ovf;
   logic [W-1:0] s_out_real, s_out_imag;
   logic         w_in_ready, w_out_valid, w_out_ovf;
   logic [W-1:0] w_out_real, w_out_imag;

   cplx_addsub_acc #(.W(W), .GUARD(4), .SATURATE(1)) u_sat (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready), .mode(mode),
      .in_last(in_last), .a_real(a_real), .a_imag(a_imag), .b_real(b_real), .b_imag(b_imag),
      .out_valid(s_out_valid), .out_ready(out_ready), .out_real(s_out_real),
      .out_imag(s_out_imag), .out_ovf(s_out_ovf));

   cplx_addsub_acc #(.W(W), .GUARD(4), .SATURATE(0)) u_wrap (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready), .mode(mode),
      .in_last(in_last), .a_real(a_real), .a_imag(a_imag), .b_real(b_real), .b_imag(b_imag),
      .out_valid(w_out_valid), .out_ready(out_ready), .out_real(w_out_real),
      .out_imag(w_out_imag), .out_ovf(w_out_ovf));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;
   int n_out = 0;

   task automatic chk(input string name, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
   endtask

   // Reference arithmetic on plain integers.
   function automatic int wrapn(input int v, input int n);
      int m;
      m = v & ((1 << n) - 1);
      if (m >= (1 << (n - 1))) m -= (1 << n);
      return m;
   endfunction

   function automatic int clipw(input int v);
      if (v > 4095) return 4095;
      if (v < -4096) return -4096;
      return v;
   endfunction

   function automatic bit oor(input int v);
      return (v > 4095) || (v < -4096);
   endfunction

   typedef struct { int re; int im; } res_t;
   res_t exp_q[$];
   int   m_acc_re, m_acc_im;
   bit   m_first;

   task automatic model_reset();
      exp_q.delete();
      m_acc_re = 0;
      m_acc_im = 0;
      m_first  = 1'b1;
   endtask

   task automatic model_accept(input logic [1:0] m, input bit l, input int ar, ai, br, bi);
      res_t r;
      int nr, ni;
      if (m == 2'b10) begin
         nr = wrapn((m_first ? 0 : m_acc_re) + ar, AW);
         ni = wrapn((m_first ? 0 : m_acc_im) + ai, AW);
         if (l) begin
            r.re = nr; r.im = ni;
            exp_q.push_back(r);
            m_first = 1'b1;
         end else begin
            m_acc_re = nr; m_acc_im = ni;
            m_first = 1'b0;
         end
      end else begin
         r.re = (m == 2'b01) ? ar - br : ar + br;
         r.im = (m == 2'b01) ? ai - bi : ai + bi;
         exp_q.push_back(r);
      end
   endtask

   // Scoreboard and hold-stability monitor, sampled on the falling edge.
   initial begin
      bit stall;
      int h_sr, h_si, h_so, h_wr, h_wi;
      res_t e;
      stall = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            stall = 1'b0;
         end else begin
            if (stall) begin
               chk("hold_valid", int'(s_out_valid), 1);
               chk("hold_sat_re", int'($signed(s_out_real)), h_sr);
               chk("hold_sat_im", int'($signed(s_out_imag)), h_si);
               chk("hold_ovf", int'(s_out_ovf), h_so);
               chk("hold_wrap_re", int'($signed(w_out_real)), h_wr);
               chk("hold_wrap_im", int'($signed(w_out_imag)), h_wi);
            end
            chk("valid_match", int'(w_out_valid), int'(s_out_valid));
            if (s_out_valid && out_ready) begin
               n_out++;
               if (exp_q.size() == 0) begin
                  chk("unexpected_out", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  chk("sb_sat_re", int'($signed(s_out_real)), clipw(e.re));
                  chk("sb_sat_im", int'($signed(s_out_imag)), clipw(e.im));
                  chk("sb_ovf", int'(s_out_ovf), int'(oor(e.re) || oor(e.im)));
                  chk("sb_wrap_re", int'($signed(w_out_real)), wrapn(e.re, W));
                  chk("sb_wrap_im", int'($signed(w_out_imag)), wrapn(e.im, W));
                  chk("sb_wrap_ovf", int'(w_out_ovf), int'(oor(e.re) || oor(e.im)));
               end
            end
            stall = s_out_valid && !out_ready;
            h_sr = $signed(s_out_real); h_si = $signed(s_out_imag); h_so = int'(s_out_ovf);
            h_wr = $signed(w_out_real); h_wi = $signed(w_out_imag);
         end
      end
   end

   // Call just after a rising edge; returns just after the accepting edge.
   task automatic send(input logic [1:0] m, input bit l, input int ar, ai, br, bi);
      bit ok;
      mode = m; in_last = l;
      a_real = ar[W-1:0]; a_imag = ai[W-1:0]; b_real = br[W-1:0]; b_imag = bi[W-1:0];
      in_valid = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 60 && !ok; k++) begin
         @(negedge clk);
         if (s_in_ready) begin
            model_accept(m, l, ar, ai, br, bi);
            ok = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!ok) chk("accept_timeout", 0, 1);
   endtask

   typedef struct {
      logic [1:0] m; bit l; int ar, ai, br, bi;
      bit has; int er, ei; bit ov; int wr, wi;
   } vec_t;
   vec_t tbl[$];

   function automatic vec_t mk(input logic [1:0] m, input bit l, input int ar, ai, br, bi,
                               input bit has, input int er, ei, input bit ov, input int wr, wi);
      vec_t v;
      v.m = m; v.l = l; v.ar = ar; v.ai = ai; v.br = br; v.bi = bi;
      v.has = has; v.er = er; v.ei = ei; v.ov = ov; v.wr = wr; v.wi = wi;
      return v;
   endfunction

   bit rnd_done;
   int out_base;

   initial begin
      #200000;
      $display("FAIL global_timeout: got timeout, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_last = 1'b0; mode = 2'b00;
      a_real = '0; a_imag = '0; b_real = '0; b_imag = '0;
      model_reset();

      tbl.push_back(mk(2'b00, 0, 4000, -100, 200, -50, 1, 4095, -150, 1, -3992, -150));
      tbl.push_back(mk(2'b01, 0, -4096, 10, 1, -5, 1, -4096, 15, 1, 4095, 15));
      tbl.push_back(mk(2'b01, 0, 100, 100, 100, -100, 1, 0, 200, 0, 0, 200));
      tbl.push_back(mk(2'b10, 0, 1000, -1000, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(2'b10, 0, 1000, -1000, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(2'b10, 1, 1000, -1000, 0, 0, 1, 3000, -3000, 0, 3000, -3000));
      for (int i = 0; i < 4; i++) tbl.push_back(mk(2'b10, 0, 1000, -1000, 77, 88, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(2'b10, 1, 1000, -1000, 77, 88, 1, 4095, -4096, 1, -3192, 3192));
      tbl.push_back(mk(2'b10, 0, 100, 200, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(2'b00, 0, 1, 2, 3, 4, 1, 4, 6, 0, 4, 6));
      tbl.push_back(mk(2'b10, 1, 10, 20, 0, 0, 1, 110, 220, 0, 110, 220));
      tbl.push_back(mk(2'b11, 0, 5, 5, 6, -7, 1, 11, -2, 0, 11, -2));
      tbl.push_back(mk(2'b10, 1, -7, 9, 0, 0, 1, -7, 9, 0, -7, 9));
      tbl.push_back(mk(2'b00, 0, -4096, -4096, -4096, 4095, 1, -4096, -1, 1, 0, -1));

      // Reset state.
      repeat (2) begin
         @(negedge clk);
         chk("rst_out_valid", int'(s_out_valid), 0);
         chk("rst_in_ready", int'(s_in_ready), 1);
         chk("rst_out_real", int'($signed(s_out_real)), 0);
         chk("rst_out_imag", int'($signed(s_out_imag)), 0);
         chk("rst_out_ovf", int'(s_out_ovf), 0);
      end
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // Vector table with exact two-edge latency.
      foreach (tbl[i]) begin
         send(tbl[i].m, tbl[i].l, tbl[i].ar, tbl[i].ai, tbl[i].br, tbl[i].bi);
         @(negedge clk);
         chk($sformatf("v%0d_early_valid", i), int'(s_out_valid), 0);
         if (tbl[i].has) begin
            @(negedge clk);
            chk($sformatf("v%0d_valid", i), int'(s_out_valid), 1);
            chk($sformatf("v%0d_sat_re", i), int'($signed(s_out_real)), tbl[i].er);
            chk($sformatf("v%0d_sat_im", i), int'($signed(s_out_imag)), tbl[i].ei);
            chk($sformatf("v%0d_ovf", i), int'(s_out_ovf), int'(tbl[i].ov));
            chk($sformatf("v%0d_wrap_re", i), int'($signed(w_out_real)), tbl[i].wr);
            chk($sformatf("v%0d_wrap_im", i), int'($signed(w_out_imag)), tbl[i].wi);
         end
         @(posedge clk); #1;
      end

      // Backpressure: six back-to-back adds, out_ready low for four cycles.
      out_base = n_out;
      fork
         begin
            for (int i = 0; i < 6; i++) send(2'b00, 0, 100 * i + 1, -50 * i, 3000, i);
         end
         begin
            @(posedge clk); #1 out_ready = 1'b0;
            @(posedge clk);
            @(negedge clk);
            chk("bp_in_ready_low", int'(s_in_ready), 0);
            chk("bp_out_valid", int'(s_out_valid), 1);
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      repeat (4) @(posedge clk);
      #1;
      chk("bp_outputs", n_out - out_base, 6);
      chk("bp_queue_empty", exp_q.size(), 0);

      // Randomized traffic with random backpressure.
      rnd_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               send(2'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0),
                    int'($urandom_range(0, 8191)) - 4096, int'($urandom_range(0, 8191)) - 4096,
                    int'($urandom_range(0, 8191)) - 4096, int'($urandom_range(0, 8191)) - 4096);
               if ($urandom_range(0, 3) == 0) begin
                  @(posedge clk); #1;
               end
            end
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk); #1;
               if (!rnd_done) out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      out_ready = 1'b1;
      for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
      #1;
      chk("rnd_drained", exp_q.size(), 0);

      // Reset in the middle of an accumulation run.
      send(2'b10, 0, 500, 500, 0, 0);
      send(2'b10, 0, 500, 500, 0, 0);
      rst_n = 1'b0;
      model_reset();
      repeat (3) begin
         @(negedge clk);
         chk("midrst_out_valid", int'(s_out_valid), 0);
         chk("midrst_in_ready", int'(s_in_ready), 1);
      end
      @(posedge clk); #1 rst_n = 1'b1;
      send(2'b10, 1, 7, 7, 0, 0);
      @(negedge clk);
      chk("midrst_early", int'(s_out_valid), 0);
      @(negedge clk);
      chk("midrst_valid", int'(s_out_valid), 1);
      chk("midrst_re", int'($signed(s_out_real)), 7);
      chk("midrst_im", int'($signed(s_out_imag)), 7);
      repeat (3) @(posedge clk);
      #1;
      chk("final_queue_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
